// File: rtl/nand_logic_pkg.sv
// Shared definitions for the NAND-only logic unit: operation encoding and its width.
package nand_logic_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'd0,
    OP_NAND = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/nand_bitwise_core.sv
// Combinational WIDTH-bit logic core; every operation is derived from 2-input NAND gates,
// with a final mux picking the requested operation.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_bitwise_core
  import nand_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] not_a, not_b, nand_ab, and_ab, or_ab, nor_ab;
  logic [WIDTH-1:0] xor_l, xor_r, xor_ab, xnor_ab, pass_a;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      nand_gate u_not_a  (.a(a[gi]),       .b(a[gi]),       .y(not_a[gi]));
      nand_gate u_not_b  (.a(b[gi]),       .b(b[gi]),       .y(not_b[gi]));
      nand_gate u_nand   (.a(a[gi]),       .b(b[gi]),       .y(nand_ab[gi]));
      nand_gate u_and    (.a(nand_ab[gi]), .b(nand_ab[gi]), .y(and_ab[gi]));
      nand_gate u_or     (.a(not_a[gi]),   .b(not_b[gi]),   .y(or_ab[gi]));
      nand_gate u_nor    (.a(or_ab[gi]),   .b(or_ab[gi]),   .y(nor_ab[gi]));
      // Classic 4-NAND XOR reuses the shared NAND(a,b) term.
      nand_gate u_xor_l  (.a(a[gi]),       .b(nand_ab[gi]), .y(xor_l[gi]));
      nand_gate u_xor_r  (.a(b[gi]),       .b(nand_ab[gi]), .y(xor_r[gi]));
      nand_gate u_xor    (.a(xor_l[gi]),   .b(xor_r[gi]),   .y(xor_ab[gi]));
      nand_gate u_xnor   (.a(xor_ab[gi]),  .b(xor_ab[gi]),  .y(xnor_ab[gi]));
      nand_gate u_pass   (.a(not_a[gi]),   .b(not_a[gi]),   .y(pass_a[gi]));
    end
  endgenerate

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_NOT:  y = not_a;
      OP_NAND: y = nand_ab;
      OP_AND:  y = and_ab;
      OP_OR:   y = or_ab;
      OP_NOR:  y = nor_ab;
      OP_XOR:  y = xor_ab;
      OP_XNOR: y = xnor_ab;
      OP_PASS: y = pass_a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/nand_logic_unit.sv
// Pipelined NAND-based logic unit: valid/ready handshake, registered result and zero flag,
// accumulator operand and a saturating count of accepted beats.
module nand_logic_unit
  import nand_logic_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic [OP_W-1:0]    op,
  input  logic               acc_sel,
  input  logic               acc_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   outY,
  output logic               zero,
  output logic [COUNT_W-1:0] xfer_count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [WIDTH-1:0]   out_y_reg, acc_reg, operand_b, result;
  logic               out_valid_reg, zero_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               accept;

  // The output stage can take a new beat when empty or when it drains this cycle.
  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign operand_b = acc_sel ? (acc_clear ? '0 : acc_reg) : inB;

  nand_bitwise_core #(.WIDTH(WIDTH)) u_core (
    .a  (inA),
    .b  (operand_b),
    .op (op),
    .y  (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_y_reg     <= '0;
      out_valid_reg <= 1'b0;
      zero_reg      <= 1'b0;
      acc_reg       <= '0;
      count_reg     <= '0;
    end else if (accept) begin
      out_y_reg     <= result;
      out_valid_reg <= 1'b1;
      zero_reg      <= (result == '0);
      acc_reg       <= result;
      if (count_reg != CNT_MAX) count_reg <= count_reg + CNT_ONE;
    end else begin
      if (out_ready) out_valid_reg <= 1'b0;
      if (acc_clear) acc_reg <= '0;
    end
  end

  assign outY       = out_y_reg;
  assign out_valid  = out_valid_reg;
  assign zero       = zero_reg;
  assign xfer_count = count_reg;

endmodule
